// File: rtl/serial_mag_compare_ctrl_if.sv
// Host-side bundle for the bit-serial magnitude comparator: request operands
// plus busy/done handshake and the registered three-way result.
interface serial_mag_compare_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;
    logic [CW-1:0]    cycles;

    modport master (
        output start, a, b,
        input  busy, done, a_gt_b, a_eq_b, a_lt_b, cycles
    );

    modport slave (
        input  start, a, b,
        output busy, done, a_gt_b, a_eq_b, a_lt_b, cycles
    );
endinterface

// File: rtl/serial_mag_compare_ctrl.sv
// Sequences one 1-bit comparator slice MSB-first over two latched WIDTH-bit
// operands; results are published only on the DONE cycle and held until the next start.
module serial_mag_compare_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_mag_compare_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic             rec_gt, rec_lt;
    logic             gt_q, eq_q, lt_q;
    logic [CW-1:0]    cycles_q;

    logic bit_a, bit_b, s_gt, s_eq, s_lt;
    logic finish, fin_gt, fin_eq, fin_lt, no_rec;

    // the single comparator slice
    assign bit_a = a_r[idx];
    assign bit_b = b_r[idx];
    assign s_gt  = bit_a & ~bit_b;
    assign s_eq  = ~(bit_a ^ bit_b);
    assign s_lt  = ~bit_a & bit_b;

    // First recorded difference wins; the current bit only counts if none was seen.
    assign no_rec = ~rec_gt & ~rec_lt;
    assign fin_gt = rec_gt | (no_rec & s_gt);
    assign fin_lt = rec_lt | (no_rec & s_lt);
    assign fin_eq = no_rec & s_eq;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        finish   = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nx = CMP;
            CMP: begin
                if ((EARLY_EXIT && (s_gt || s_lt)) || idx == '0) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            idx      <= '0;
            cnt      <= '0;
            rec_gt   <= 1'b0;
            rec_lt   <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            cycles_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        idx    <= IW'(WIDTH - 1);
                        cnt    <= '0;
                        rec_gt <= 1'b0;
                        rec_lt <= 1'b0;
                        gt_q   <= 1'b0;
                        eq_q   <= 1'b0;
                        lt_q   <= 1'b0;
                    end
                end
                CMP: begin
                    cnt <= cnt + 1'b1;
                    idx <= idx - 1'b1;
                    if (no_rec) begin
                        rec_gt <= s_gt;
                        rec_lt <= s_lt;
                    end
                    if (finish) begin
                        gt_q     <= fin_gt;
                        eq_q     <= fin_eq;
                        lt_q     <= fin_lt;
                        cycles_q <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.a_gt_b = gt_q;
    assign bus.a_eq_b = eq_q;
    assign bus.a_lt_b = lt_q;
    assign bus.cycles = cycles_q;
endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Bench for serial_mag_compare_ctrl: early-exit and constant-time instances share
// stimulus and are checked every cycle against a transaction-level model.
module tb_serial_mag_compare_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b1;
    logic [7:0] a = '0, b = '0;
    int         tests = 0, fails = 0;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_mag_compare_ctrl_if #(.WIDTH(8)) i0 ();
    serial_mag_compare_ctrl_if #(.WIDTH(8)) i1 ();

    assign i0.start = start;
    assign i0.a     = a;
    assign i0.b     = b;
    assign i1.start = start;
    assign i1.a     = a;
    assign i1.b     = b;

    serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) d0 (.clk(clk), .rst(rst), .bus(i0));
    serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) d1 (.clk(clk), .rst(rst), .bus(i1));

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Whole-operand answer: ordering by integer compare, cost from the top differing bit.
    function automatic void ref_cmp(input bit ee, input logic [7:0] xa, input logic [7:0] xb,
                                    output int k, output logic [2:0] flags);
        logic [7:0] x;
        int m;
        flags = {xa > xb, xa == xb, xa < xb};
        x = xa ^ xb;
        m = 0;
        for (int i = 0; i < 8; i++) if (x[i]) m = i;
        k = (!ee || xa == xb) ? 8 : 8 - m;
    endfunction

    // model per instance: 0 = early exit, 1 = constant time
    logic       mb[2], md[2];
    logic [2:0] mf[2], pf[2];
    logic [3:0] mc[2];
    int         tmr[2], pk[2];

    always @(posedge clk) begin
        int k;
        logic [2:0] f;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                mb[d] = 1'b0; md[d] = 1'b0; mf[d] = '0; mc[d] = '0; tmr[d] = 0;
            end else if (!mb[d]) begin
                if (start) begin
                    ref_cmp(d == 0, a, b, k, f);
                    pf[d] = f; pk[d] = k; tmr[d] = k;
                    mb[d] = 1'b1; mf[d] = '0;
                end
            end else if (md[d]) begin
                md[d] = 1'b0; mb[d] = 1'b0;
            end else begin
                tmr[d]--;
                if (tmr[d] == 0) begin
                    md[d] = 1'b1; mf[d] = pf[d]; mc[d] = 4'(pk[d]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dut0 outputs", {7'b0, i0.busy, i0.done, i0.a_gt_b, i0.a_eq_b, i0.a_lt_b, i0.cycles},
                {7'b0, mb[0], md[0], mf[0], mc[0]});
            chk("dut1 outputs", {7'b0, i1.busy, i1.done, i1.a_gt_b, i1.a_eq_b, i1.a_lt_b, i1.cycles},
                {7'b0, mb[1], md[1], mf[1], mc[1]});
        end
    end

    task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, output int lat);
        @(negedge clk); start = 1'b1; a = xa; b = xb;
        @(negedge clk); start = 1'b0; lat = 1;
        while (i0.done !== 1'b1 && lat < 40) begin
            @(negedge clk); lat++;
        end
        if (lat >= 40) chk("done timeout", 16'(lat), 16'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((i0.busy !== 1'b0 || i1.busy !== 1'b0) && n < 40) begin
            @(negedge clk); n++;
        end
        if (n >= 40) chk("idle timeout", 16'(n), 16'd0);
    endtask

    initial begin
        int lat, k, ndone;
        logic [2:0] f;

        // model pins
        ref_cmp(1'b1, 8'hA5, 8'h25, k, f); chk("model k A5/25 ee", 16'(k), 16'd1); chk("model f A5/25", 16'(f), 16'b100);
        ref_cmp(1'b1, 8'h40, 8'h41, k, f); chk("model k 40/41 ee", 16'(k), 16'd8); chk("model f 40/41", 16'(f), 16'b001);
        ref_cmp(1'b1, 8'h10, 8'h20, k, f); chk("model k 10/20 ee", 16'(k), 16'd3);
        ref_cmp(1'b0, 8'hA5, 8'h25, k, f); chk("model k A5/25 ct", 16'(k), 16'd8);
        ref_cmp(1'b1, 8'h3C, 8'h3C, k, f); chk("model k 3C/3C", 16'(k), 16'd8); chk("model f 3C/3C", 16'(f), 16'b010);

        // reset held with start asserted
        @(negedge clk); @(negedge clk);
        chk_en = 1'b1;
        chk("reset state", {i0.busy, i0.done, i0.a_gt_b, i0.a_eq_b, i0.a_lt_b, i0.cycles}, 16'd0);
        rst = 1'b0; start = 1'b0;

        do_op(8'hA5, 8'h25, lat);
        chk("A5>25 latency", 16'(lat), 16'd2);
        chk("A5>25 gt", 16'(i0.a_gt_b), 16'd1);
        chk("A5>25 cycles", 16'(i0.cycles), 16'd1);
        wait_idle();
        chk("A5>25 ct gt+cycles", {i1.a_gt_b, i1.cycles}, {1'b1, 4'd8});

        do_op(8'h3C, 8'h3C, lat);
        chk("3C eq latency", 16'(lat), 16'd9);
        chk("3C eq flags", {i0.a_gt_b, i0.a_eq_b, i0.a_lt_b}, 16'b010);
        chk("3C eq cycles", 16'(i0.cycles), 16'd8);
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("eq hold", {i0.a_eq_b, i1.a_eq_b}, 16'b11);
        end

        do_op(8'h40, 8'h41, lat);
        chk("40<41 latency", 16'(lat), 16'd9);
        chk("40<41 lt+cycles", {i0.a_lt_b, i0.cycles}, {1'b1, 4'd8});
        wait_idle();
        chk("40<41 ct lt+cycles", {i1.a_lt_b, i1.cycles}, {1'b1, 4'd8});

        // start while busy is ignored
        @(negedge clk); start = 1'b1; a = 8'h10; b = 8'h20;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; a = 8'hFF; b = 8'h00;
        @(negedge clk); start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); if (i0.done === 1'b1) ndone++;
        end
        chk("busy start dones", 16'(ndone), 16'd1);
        chk("busy start flags", {i0.a_gt_b, i0.a_eq_b, i0.a_lt_b, i0.cycles}, {3'b001, 4'd3});

        // reset in the 3rd CMP cycle
        @(negedge clk); start = 1'b1; a = 8'h3C; b = 8'h3C;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("mid reset", {i0.busy, i0.done, i0.a_gt_b, i0.a_eq_b, i0.a_lt_b, i1.busy}, 16'd0);
        do_op(8'hA5, 8'h25, lat);
        chk("post reset latency", 16'(lat), 16'd2);
        chk("post reset gt", 16'(i0.a_gt_b), 16'd1);
        wait_idle();

        // random traffic, including operand churn while busy and rare resets
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (8'h01 << $urandom_range(0, 7));
                default: b = 8'($urandom);
            endcase
            rst = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk); rst = 1'b0; start = 1'b0;
        wait_idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
